stream_demultiplexer: RTL
=========================

Name: stream_demultiplexer

Overview:
- Inverse of the two-input selector: takes one byte stream and routes each packet to output channel A or channel B.
- The route is chosen by `in_sel`, sampled on the first beat of each packet and held until that packet's last beat.
- Uses valid/ready handshakes on all three interfaces. Each output has a one-entry holding register.
- Keeps saturating per-channel packet counters for debug and status.

Parameters:
- WIDTH, 8, data width of input and output beats.
- CNT_W, 8, width of each per-channel completed-packet counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  input beat data.
- in_valid  input  1  input beat offered.
- in_last  input  1  final beat of the current packet.
- in_sel  input  1  route select (0 = A, 1 = B); only meaningful on the first beat.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- a_data  output  WIDTH  channel A data.
- a_valid  output  1  channel A beat present.
- a_last  output  1  channel A end of packet.
- a_ready  input  1  channel A downstream ready.
- b_data  output  WIDTH  channel B data.
- b_valid  output  1  channel B beat present.
- b_last  output  1  channel B end of packet.
- b_ready  input  1  channel B downstream ready.
- a_count  output  CNT_W  completed packets routed to A.
- b_count  output  CNT_W  completed packets routed to B.

Behaviour:
- Reset (async, rst_n low): state=IDLE; a_valid/b_valid=0; a_data/b_data=0; a_last/b_last=0; a_count/b_count=0; in_ready=0 while rst_n low.
- Reset asserted mid-packet discards the packet and any held beats. No partial count is recorded.
- FSM states: IDLE, ROUTE_A, ROUTE_B.
- Target channel:
  - In IDLE: in_sel (combinational).
  - In ROUTE_A: A.
  - In ROUTE_B: B.
- in_ready = target slot empty OR target slot draining this cycle (valid && ready). The non-target slot never gates in_ready.
- Accepted beat in IDLE:
  - Beat goes to the target slot.
  - If in_last=1: remain IDLE (single-beat packet) and increment the target counter.
  - If in_last=0: go to ROUTE_A or ROUTE_B per sampled in_sel.
- Accepted beat in ROUTE_x:
  - in_sel is ignored.
  - If in_last=1: return to IDLE and increment x's counter on the same edge.
- No accepted beat: state holds, including in_valid high with in_ready low.
- Latency: accepted beat appears on x_data/x_valid/x_last on the next rising edge (1 cycle).
- Throughput: 1 beat/cycle when the target downstream ready is held high. A simultaneous drain and fill of one slot in the same cycle is legal and required.
- Slot stability: while x_valid && !x_ready, x_data and x_last hold stable.
- Slot contents: x_valid deasserts only on drain without refill. Data/last of an empty slot are don't-care but hold their last value.
- Channels are independent: A may stall while B drains, and vice versa. A new packet may start on the other channel while the previous channel's slot still holds its last beat.
- Counters: increment on acceptance of a last beat (not on drain), and saturate at all-ones with no wrap.
- Only one counter can increment per cycle.
- No reordering and no drops: beats leave each channel in acceptance order.
- in_valid must not depend on in_ready.

Decomposition:
- Shared package `stream_demux_pkg`:
  - state enum {IDLE, ROUTE_A, ROUTE_B};
  - constants SEL_A=1'b0, SEL_B=1'b1.
- Sub-module `demux_out_slot` (WIDTH param), instantiated twice:
  - one-entry register with load/valid/ready;
  - provides "can_accept = !valid || ready" to the top-level ready logic.
- Top level holds the FSM, in_ready mux, load steering and counters.

Test Plan:
- Single-beat: in_sel=0, in_data=0x5A, in_last=1, a_ready=1 → a_valid high next cycle with a_data=0x5A, a_last=1; a_count=1; b_valid stays 0; state IDLE.
- Multi-beat sticky select: 4-beat packet 0x01..0x04 with in_sel=1 on beat 1 and in_sel toggling on beats 2–4 → all four beats appear on B in order; b_last only on 0x04; b_count=1; a_count=0.
- Backpressure: 3-beat packet to A with a_ready=0 for 5 cycles after beat 1 → in_ready=0 after first acceptance; a_data=first beat held stable; after a_ready=1 the remaining beats flow at 1/cycle.
- Independent channels: A holds its last beat with a_ready=0; a new packet to B (in_sel=1, 0xC3, last) → accepted immediately, b_data=0xC3 next cycle, A data unchanged.
- Saturation: CNT_W=2, five single-beat packets to A → a_count reads 1,2,3,3,3.
- Async reset mid-packet: deassert rst_n after beat 2 of a 4-beat packet to B, between clock edges → b_valid=0, counts=0 immediately. After release, in_sel=0 on the next beat routes to A (state was IDLE).

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer and its output slots.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE_A = 2'd1,
        ROUTE_B = 2'd2
    } state_t;

    localparam logic SEL_A  = 1'b0;
    localparam logic SEL_B  = 1'b1;
    localparam int   NUM_CH = 2;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding register with valid/ready handshake.
module demux_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             last,
    output logic             can_accept
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic             last_reg;

    // A slot draining this cycle can take a new beat on the same edge.
    assign can_accept = !valid_reg || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            valid_reg <= 1'b1;
            last_reg  <= load_last;
        end else if (ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;
    assign last  = last_reg;

endmodule

// File: rtl/stream_demultiplexer.sv
// Routes each input packet to channel A or B, selected on its first beat.
module stream_demultiplexer
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             in_sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    output logic             a_last,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    output logic             b_last,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    state_t state_reg;
    state_t state_next;

    logic                  target_sel;
    logic                  accept;
    logic [NUM_CH-1:0]     slot_load;
    logic [NUM_CH-1:0]     slot_ready;
    logic [NUM_CH-1:0]     slot_valid;
    logic [NUM_CH-1:0]     slot_last;
    logic [NUM_CH-1:0]     slot_can;
    logic [WIDTH-1:0]      slot_data [NUM_CH];
    logic [CNT_W-1:0]      cnt_reg   [NUM_CH];

    assign slot_ready = {b_ready, a_ready};

    always_comb begin
        target_sel = in_sel;
        case (state_reg)
            IDLE:    target_sel = in_sel;
            ROUTE_A: target_sel = SEL_A;
            ROUTE_B: target_sel = SEL_B;
            default: target_sel = in_sel;
        endcase
    end

    // Only the channel currently being fed can stall the input.
    assign in_ready = rst_n && slot_can[target_sel];
    assign accept   = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            assign slot_load[gi] = accept && (target_sel == 1'(gi));

            demux_out_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk        (clk),
                .rst_n      (rst_n),
                .load       (slot_load[gi]),
                .load_data  (in_data),
                .load_last  (in_last),
                .ready      (slot_ready[gi]),
                .data       (slot_data[gi]),
                .valid      (slot_valid[gi]),
                .last       (slot_last[gi]),
                .can_accept (slot_can[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && !in_last) begin
                    state_next = (target_sel == SEL_B) ? ROUTE_B : ROUTE_A;
                end
            end
            ROUTE_A, ROUTE_B: begin
                if (accept && in_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Packets are counted when their last beat is accepted, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (slot_load[i] && in_last && (cnt_reg[i] != {CNT_W{1'b1}})) begin
                    cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
                end
            end
        end
    end

    assign a_data  = slot_data[0];
    assign a_valid = slot_valid[0];
    assign a_last  = slot_last[0];
    assign b_data  = slot_data[1];
    assign b_valid = slot_valid[1];
    assign b_last  = slot_last[1];
    assign a_count = cnt_reg[0];
    assign b_count = cnt_reg[1];

endmodule
